sample_frame_receiver: RTL and testbench
========================================

SAMPLE_FRAME_RECEIVER -- requirements
Module: sample_frame_receiver

Interface
REQ-001 SHALL have parameter CMD_START, default 8'h00, meaning the command byte that starts remote streaming.
REQ-002 SHALL have parameter CMD_STOP, default 8'h01, meaning the command byte that stops remote streaming (any non-start code).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16'd2000, meaning the inter-byte timeout limit in clk cycles.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  single-cycle request to begin streaming.
REQ-007 stop  input  1  single-cycle request to end streaming.
REQ-008 tx_busy  input  1  UART transmitter busy.
REQ-009 tx_send  output  1  single-cycle pulse that loads tx_data into the UART transmitter.
REQ-010 tx_data  output  8  command byte.
REQ-011 rx_ready  input  1  single-cycle pulse; rx_data is valid in that cycle.
REQ-012 rx_data  input  8  received byte.
REQ-013 sample  output  24  last complete sample.
REQ-014 sample_valid  output  1  single-cycle pulse when sample updates.
REQ-015 timeout_err  output  1  single-cycle pulse when a partial frame is dropped.
REQ-016 streaming  output  1  high from start acceptance until stop acceptance.

Function
REQ-017 SHALL implement the states IDLE, SEND_START, RX_B0, RX_B1, RX_B2 and SEND_STOP.
REQ-018 IDLE: on start, SHALL go to SEND_START; rx_ready is ignored in this state.
REQ-019 SEND_START / SEND_STOP:
- SHALL drive tx_data = CMD_START / CMD_STOP.
- SHALL wait while tx_busy=1.
- In the first cycle with tx_busy=0, SHALL pulse tx_send for exactly one cycle.
- Next state: RX_B0 after SEND_START; IDLE after SEND_STOP.
REQ-020 tx_data SHALL hold its value from the tx_send cycle until the next tx_send.
REQ-021 RX_B0/RX_B1/RX_B2 on rx_ready: SHALL capture rx_data into byte slot 0/1/2 respectively.
REQ-022 Byte order SHALL be LSB first: byte 0 maps to sample[7:0], byte 1 to sample[15:8], byte 2 to sample[23:16].
REQ-023 On the rx_ready that delivers byte 2:
- sample SHALL update and sample_valid SHALL pulse in the next cycle (1-cycle latency).
- State SHALL return to RX_B0; streaming continues with no new command.
REQ-024 sample SHALL hold its value between frames; a partial frame SHALL never alter sample.
REQ-025 Timeout counter, 16 bits:
- Cleared on every state change and on every rx_ready.
- Runs only in RX_B1 and RX_B2.
- On reaching TIMEOUT_CYCLES: SHALL discard the partial frame, pulse timeout_err, and go to RX_B0.
REQ-026 The counter SHALL saturate and never wrap.
REQ-027 stop while in RX_B0..RX_B2 SHALL discard any partial frame and go to SEND_STOP, even if rx_ready is high in the same cycle (the byte is dropped).
REQ-028 start and stop in the same cycle: stop SHALL win; from IDLE, no command is sent.
REQ-029 start while streaming, and stop in IDLE or SEND_*, SHALL be ignored.
REQ-030 rx_ready in SEND_START or SEND_STOP SHALL be ignored.
REQ-031 timeout and rx_ready in the same cycle: rx_ready SHALL win.

Reset
REQ-032 On reset, SHALL set state=IDLE; tx_send=0, tx_data=8'h00, sample=0, sample_valid=0, timeout_err=0, streaming=0, and the counter to 0.
REQ-033 Reset mid-transaction SHALL abort without emitting tx_send, sample_valid or timeout_err in the following cycle.

Configuration
REQ-034 Macro FRAME_TIMEOUT_EN defined: SHALL include the timeout behaviour per REQ-025, REQ-026 and REQ-031.
REQ-035 Macro FRAME_TIMEOUT_EN undefined:
- No counter is implemented.
- timeout_err SHALL be tied to 0.
- RX_B1/RX_B2 SHALL wait indefinitely for the next byte.

Verification
REQ-036 start pulse, tx_busy=0 -> tx_send for 1 cycle with tx_data=8'h00; streaming=1.
REQ-037 rx bytes 0x34, 0x12, 0xAB -> sample=24'hAB1234, a single sample_valid pulse one cycle after the third rx_ready.
REQ-038 tx_busy=1 for 50 cycles after start -> tx_send asserted exactly in the first cycle with tx_busy=0.
REQ-039 One byte then silence for TIMEOUT_CYCLES (FRAME_TIMEOUT_EN defined) -> timeout_err pulse, sample unchanged; the next 3 bytes form a correct sample.
REQ-040 stop during RX_B1 -> tx_send with tx_data=8'h01, state returns to IDLE, streaming=0, no sample_valid.
REQ-041 start and stop in the same cycle from IDLE -> no tx_send; reset during RX_B2 -> all outputs at their reset values.

Source files
------------

// File: rtl/sample_frame_receiver.sv
// Commands a remote UART sender to start/stop streaming and assembles 3-byte
// LSB-first frames into 24-bit samples. Optional inter-byte timeout: FRAME_TIMEOUT_EN.
module sample_frame_receiver #(
    parameter logic [7:0]  CMD_START      = 8'h00,
    parameter logic [7:0]  CMD_STOP       = 8'h01,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        tx_busy,
    output logic        tx_send,
    output logic [7:0]  tx_data,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic [23:0] sample,
    output logic        sample_valid,
    output logic        timeout_err,
    output logic        streaming
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SEND_START = 3'd1,
        RX_B0      = 3'd2,
        RX_B1      = 3'd3,
        RX_B2      = 3'd4,
        SEND_STOP  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  byte0_q, byte0_d;
    logic [7:0]  byte1_q, byte1_d;
    logic [23:0] sample_q, sample_d;
    logic        sample_valid_q, sample_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [7:0]  tx_out;
    logic        tx_send_c;
    logic        timeout_hit;
    logic        in_gap;

    // Only the gaps between bytes of a started frame are timed.
    assign in_gap = (state_q == RX_B1) || (state_q == RX_B2);

    always_comb begin
        state_d        = state_q;
        byte0_d        = byte0_q;
        byte1_d        = byte1_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        tx_data_d      = tx_data_q;
        tx_out         = tx_data_q;
        tx_send_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = SEND_START;
                end
            end
            SEND_START: begin
                tx_out = CMD_START;
                if (!tx_busy) begin
                    tx_send_c = 1'b1;
                    tx_data_d = CMD_START;
                    state_d   = RX_B0;
                end
            end
            RX_B0: begin
                if (stop) begin
                    state_d = SEND_STOP;
                end else if (rx_ready) begin
                    byte0_d = rx_data;
                    state_d = RX_B1;
                end
            end
            RX_B1: begin
                if (stop) begin
                    state_d = SEND_STOP;
                end else if (rx_ready) begin
                    byte1_d = rx_data;
                    state_d = RX_B2;
                end else if (timeout_hit) begin
                    state_d = RX_B0;
                end
            end
            RX_B2: begin
                if (stop) begin
                    state_d = SEND_STOP;
                end else if (rx_ready) begin
                    sample_d       = {rx_data, byte1_q, byte0_q};
                    sample_valid_d = 1'b1;
                    state_d        = RX_B0;
                end else if (timeout_hit) begin
                    state_d = RX_B0;
                end
            end
            SEND_STOP: begin
                tx_out = CMD_STOP;
                if (!tx_busy) begin
                    tx_send_c = 1'b1;
                    tx_data_d = CMD_STOP;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            byte0_q        <= 8'h00;
            byte1_q        <= 8'h00;
            sample_q       <= 24'h000000;
            sample_valid_q <= 1'b0;
            tx_data_q      <= 8'h00;
        end else begin
            state_q        <= state_d;
            byte0_q        <= byte0_d;
            byte1_q        <= byte1_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            tx_data_q      <= tx_data_d;
        end
    end

`ifdef FRAME_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_err_q;

    assign timeout_hit = in_gap && (cnt_q >= TIMEOUT_CYCLES);

    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || rx_ready) begin
            cnt_d = 16'h0000;
        end else if (in_gap && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'h0001;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= 16'h0000;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            // A byte or a stop arriving in the expiry cycle takes priority.
            timeout_err_q <= timeout_hit && !rx_ready && !stop;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign tx_send      = tx_send_c && !reset;
    assign tx_data      = tx_out;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign streaming    = (state_q == SEND_START) || (state_q == RX_B0) || in_gap;

endmodule

// File: tb/tb_sample_frame_receiver.sv
// Randomized self-checking bench for sample_frame_receiver; frames are checked
// against a queue of expected 24-bit samples built from the transmitted bytes.
module tb_sample_frame_receiver;

    localparam logic [15:0] TO = 16'd100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        tx_busy = 1'b0;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic [23:0] sample;
    logic        sample_valid;
    logic        timeout_err;
    logic        streaming;

    int tests = 0;
    int fails = 0;

    int          n_send = 0;
    int          n_valid = 0;
    int          n_to = 0;
    logic [23:0] got_q[$];

    sample_frame_receiver #(
        .CMD_START(8'h00),
        .CMD_STOP(8'h01),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stop(stop),
        .tx_busy(tx_busy),
        .tx_send(tx_send),
        .tx_data(tx_data),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .sample(sample),
        .sample_valid(sample_valid),
        .timeout_err(timeout_err),
        .streaming(streaming)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_send) n_send++;
        if (sample_valid) begin
            n_valid++;
            got_q.push_back(sample);
        end
        if (timeout_err) n_to++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        tests++;
        if ({tx_send, tx_data, sample, sample_valid, timeout_err, streaming} !== 36'h0) begin
            fails++;
            $display("FAIL reset_outputs got %h want 0",
                     {tx_send, tx_data, sample, sample_valid, timeout_err, streaming});
        end
        tick();
        reset = 1'b0;
        tick();
        $display("[TB] reset done");
    endtask

    task automatic test_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        tests++;
        if ({tx_send, tx_data, streaming} !== {1'b1, 8'h00, 1'b1}) begin
            fails++;
            $display("FAIL start_send got send=%b data=%h str=%b want 1 00 1", tx_send, tx_data, streaming);
        end
        tick();
        @(negedge clk);
        tests++;
        if ({tx_send, streaming} !== 2'b01) begin
            fails++;
            $display("FAIL start_single got send=%b str=%b want 0 1", tx_send, streaming);
        end
        $display("[TB] start command checked");
    endtask

    task automatic test_frame();
        int v0;
        v0 = n_valid;
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'hAB);
        @(negedge clk);
        tests++;
        if ({sample_valid, sample} !== {1'b1, 24'hAB1234}) begin
            fails++;
            $display("FAIL frame_sample got v=%b s=%h want 1 ab1234", sample_valid, sample);
        end
        tick();
        @(negedge clk);
        tests++;
        if (sample_valid !== 1'b0 || (n_valid - v0) != 1) begin
            fails++;
            $display("FAIL frame_pulse got v=%b count=%0d want 0 1", sample_valid, n_valid - v0);
        end
        $display("[TB] frame 34 12 ab -> %h", sample);
    endtask

    task automatic test_random_frames();
        logic [23:0] exp_q[$];
        logic [7:0]  b;
        logic [23:0] frame;
        int          s0;
        int          bad;
        got_q.delete();
        s0 = n_send;
        for (int f = 0; f < 30; f++) begin
            frame = 24'h0;
            for (int k = 0; k < 3; k++) begin
                int gap;
                gap = $urandom_range(0, 20);
                for (int g = 0; g < gap; g++) begin
                    start = ($urandom_range(0, 3) == 0);
                    tick();
                    start = 1'b0;
                end
                b = 8'($urandom);
                frame[k*8 +: 8] = b;
                send_byte(b);
            end
            exp_q.push_back(frame);
        end
        tick();
        tick();
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                if (bad < 4) $display("FAIL rand_sample[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        tests++;
        if (bad != 0) fails++;
        tests++;
        if ((n_send - s0) != 0 || sample !== exp_q[exp_q.size()-1]) begin
            fails++;
            $display("FAIL rand_hold got sends=%0d s=%h want 0 %h", n_send - s0, sample, exp_q[exp_q.size()-1]);
        end
        $display("[TB] random frames: %0d received, %0d expected", got_q.size(), exp_q.size());
    endtask

    task automatic test_timeout();
        int          v0;
        int          t0;
        int          first;
        logic [23:0] s0;
        v0 = n_valid;
        t0 = n_to;
        s0 = sample;
        first = -1;
`ifdef FRAME_TIMEOUT_EN
        send_byte(8'h77);
        for (int k = 0; k < int'(TO) + 10; k++) begin
            @(negedge clk);
            if (timeout_err && first < 0) first = k;
            tick();
        end
        tests++;
        if (first != int'(TO) + 1 || (n_to - t0) != 1) begin
            fails++;
            $display("FAIL timeout_pulse got cycle=%0d count=%0d want %0d 1", first, n_to - t0, int'(TO) + 1);
        end
        tests++;
        if (sample !== s0 || n_valid != v0) begin
            fails++;
            $display("FAIL timeout_drop got s=%h valids=%0d want %h 0", sample, n_valid - v0, s0);
        end
        send_byte(8'hC3);
        send_byte(8'hB2);
        send_byte(8'hA1);
        @(negedge clk);
        tests++;
        if ({sample_valid, sample} !== {1'b1, 24'hA1B2C3}) begin
            fails++;
            $display("FAIL timeout_recover got v=%b s=%h want 1 a1b2c3", sample_valid, sample);
        end
        t0 = n_to;
        send_byte(8'h11);
        repeat (int'(TO)) tick();
        send_byte(8'h22);
        send_byte(8'h33);
        tick();
        tick();
        tests++;
        if (sample !== 24'h332211 || n_to != t0) begin
            fails++;
            $display("FAIL timeout_rx_wins got s=%h to=%0d want 332211 0", sample, n_to - t0);
        end
`else
        send_byte(8'h77);
        repeat (3 * int'(TO)) tick();
        tests++;
        if (n_to != t0 || n_valid != v0 || sample !== s0) begin
            fails++;
            $display("FAIL no_timeout got to=%0d valids=%0d s=%h want 0 0 %h", n_to - t0, n_valid - v0, sample, s0);
        end
        send_byte(8'h88);
        send_byte(8'h99);
        @(negedge clk);
        tests++;
        if ({sample_valid, sample} !== {1'b1, 24'h998877}) begin
            fails++;
            $display("FAIL no_timeout_frame got v=%b s=%h want 1 998877", sample_valid, sample);
        end
        tick();
`endif
        $display("[TB] timeout behaviour checked, first pulse cycle %0d", first);
    endtask

    task automatic test_stop_mid();
        int          v0;
        int          s0;
        logic [23:0] smp0;
        v0 = n_valid;
        smp0 = sample;
        send_byte(8'h55);
        stop = 1'b1;
        rx_ready = 1'b1;
        rx_data = 8'h66;
        tick();
        stop = 1'b0;
        rx_ready = 1'b0;
        @(negedge clk);
        tests++;
        if ({tx_send, tx_data, streaming} !== {1'b1, 8'h01, 1'b0}) begin
            fails++;
            $display("FAIL stop_send got send=%b data=%h str=%b want 1 01 0", tx_send, tx_data, streaming);
        end
        tick();
        @(negedge clk);
        tests++;
        if ({tx_send, tx_data, streaming} !== {1'b0, 8'h01, 1'b0}) begin
            fails++;
            $display("FAIL stop_hold got send=%b data=%h str=%b want 0 01 0", tx_send, tx_data, streaming);
        end
        s0 = n_send;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        tick();
        tests++;
        if (n_valid != v0 || sample !== smp0 || n_send != s0) begin
            fails++;
            $display("FAIL stop_idle got valids=%0d s=%h sends=%0d want 0 %h 0", n_valid - v0, sample, n_send - s0, smp0);
        end
        $display("[TB] stop mid-frame checked");
    endtask

    task automatic test_start_stop_same();
        int s0;
        s0 = n_send;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        tests++;
        if ((n_send - s0) != 0 || streaming !== 1'b0) begin
            fails++;
            $display("FAIL start_stop_same got sends=%0d str=%b want 0 0", n_send - s0, streaming);
        end
        $display("[TB] simultaneous start/stop checked");
    endtask

    task automatic test_start_busy();
        int s0;
        int early;
        s0 = n_send;
        early = 0;
        tx_busy = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            stop = (i == 10);
            @(negedge clk);
            if (tx_send !== 1'b0) early++;
            tick();
            stop = 1'b0;
        end
        tests++;
        if (early != 0) begin
            fails++;
            $display("FAIL busy_wait got %0d early sends want 0", early);
        end
        tx_busy = 1'b0;
        @(negedge clk);
        tests++;
        if ({tx_send, tx_data, streaming} !== {1'b1, 8'h00, 1'b1}) begin
            fails++;
            $display("FAIL busy_release got send=%b data=%h str=%b want 1 00 1", tx_send, tx_data, streaming);
        end
        tick();
        @(negedge clk);
        tests++;
        if (tx_send !== 1'b0 || (n_send - s0) != 1 || streaming !== 1'b1) begin
            fails++;
            $display("FAIL busy_single got send=%b count=%0d str=%b want 0 1 1", tx_send, n_send - s0, streaming);
        end
        $display("[TB] start under tx_busy checked");
    endtask

    task automatic test_reset_mid();
        int v0;
        int s0;
        int t0;
        send_byte(8'hD1);
        send_byte(8'hD2);
        v0 = n_valid;
        s0 = n_send;
        t0 = n_to;
        reset = 1'b1;
        rx_ready = 1'b1;
        rx_data = 8'hEE;
        tick();
        reset = 1'b0;
        rx_ready = 1'b0;
        @(negedge clk);
        tests++;
        if ({tx_send, tx_data, sample, sample_valid, timeout_err, streaming} !== 36'h0) begin
            fails++;
            $display("FAIL reset_mid got %h want 0",
                     {tx_send, tx_data, sample, sample_valid, timeout_err, streaming});
        end
        tick();
        tick();
        tests++;
        if (n_valid != v0 || n_send != s0 || n_to != t0 || streaming !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_after got v=%0d s=%0d t=%0d str=%b want 0 0 0 0",
                     n_valid - v0, n_send - s0, n_to - t0, streaming);
        end
        $display("[TB] reset mid-frame checked");
    endtask

    initial begin
        test_reset();
        test_start();
        test_frame();
        test_random_frames();
        test_timeout();
        test_stop_mid();
        test_start_stop_same();
        test_start_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
